// File: rtl/cla_seq_adder16.sv
// Sequential 16-bit adder that pushes one nibble per cycle through an external
// 4-bit carry-lookahead adder, chaining its carry-out between nibbles.
module cla_seq_adder16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [3:0]  cla_a,
  output logic [3:0]  cla_b,
  output logic        cla_cin,
  input  logic [3:0]  cla_s,
  input  logic        cla_c3,
  input  logic        cla_cout,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] a_reg, b_reg, sum_reg;
  logic        cin_reg, carry_reg, cout_reg, ovf_reg;
  logic [1:0]  idx_reg;
  logic        accept;

  logic [3:0]  a_nib [4];
  logic [3:0]  b_nib [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  // A new request is taken in IDLE or DONE, never mid-addition.
  assign accept = start && (state_reg != ADD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ADD;
      ADD:     if (idx_reg == 2'd3) state_next = DONE;
      DONE:    state_next = accept ? ADD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      idx_reg   <= 2'd0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      cin_reg <= cin;
      idx_reg <= 2'd0;
    end else if (state_reg == ADD) begin
      sum_reg[{idx_reg, 2'b00} +: 4] <= cla_s;
      carry_reg <= cla_cout;
      idx_reg   <= idx_reg + 2'd1;
      if (idx_reg == 2'd3) begin
        cout_reg <= cla_cout;
        ovf_reg  <= cla_c3 ^ cla_cout;
      end
    end
  end

  always_comb begin
    busy    = (state_reg == ADD);
    done    = (state_reg == DONE);
    cla_a   = 4'd0;
    cla_b   = 4'd0;
    cla_cin = 1'b0;
    if (state_reg == ADD) begin
      cla_a   = a_nib[idx_reg];
      cla_b   = b_nib[idx_reg];
      cla_cin = (idx_reg == 2'd0) ? cin_reg : carry_reg;
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_cla_seq_adder16.sv
// Bench for cla_seq_adder16: models the external 4-bit CLA, issues directed
// additions and checks results, latency and busy width through a scoreboard.
module tb_cla_seq_adder16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic [3:0]  cla_a, cla_b, cla_s;
  logic        cla_cin, cla_c3, cla_cout;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          done_cyc;
  } exp_t;
  exp_t q[$];

  cla_seq_adder16 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_s(cla_s), .cla_c3(cla_c3), .cla_cout(cla_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  // External 4-bit CLA behaviour
  logic [4:0] full5;
  logic [3:0] low4;
  assign full5    = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};
  assign low4     = {1'b0, cla_a[2:0]} + {1'b0, cla_b[2:0]} + {3'b0, cla_cin};
  assign cla_s    = full5[3:0];
  assign cla_cout = full5[4];
  assign cla_c3   = low4[3];

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.done_cyc = cyc + 5;
    q.push_back(e);
  endtask

  // Monitor: done pulses, busy run length, idle CLA-port values
  int busy_run = 0;
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", sum, e.sum);
        chk("cout", cout, e.cout);
        chk("ovf", ovf, e.ovf);
        chk("latency", cyc, e.done_cyc);
        $display("done cyc=%0d sum=%04h cout=%0b ovf=%0b", cyc, sum, cout, ovf);
      end
    end
    if (!rst_n) begin
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else begin
      if (busy_run != 0) chk("busy_width", busy_run, 4);
      busy_run = 0;
      chk("idle_cla_port", {cla_a, cla_b, cla_cin}, 0);
    end
  end

  task automatic op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                    input logic [15:0] es, input logic ec, input logic eo);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; cin = ic;
    push_exp(es, ec, eo);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_all_zero();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cla", {cla_a, cla_b, cla_cin}, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    chk_all_zero();
    @(negedge clk);
    #5 rst_n = 1'b1;

    op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
    op(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0);

    // start held through ADD with different operands: original result stands
    @(negedge clk);
    start = 1'b1; a = 16'h0123; b = 16'h0456; cin = 1'b1;
    push_exp(16'h057A, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);

    // back-to-back: new start accepted in the DONE cycle
    @(negedge clk);
    start = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    push_exp(16'h0100, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("in_done_cycle", done, 1);
    start = 1'b1; a = 16'h0F0F; b = 16'h00F1; cin = 1'b0;
    push_exp(16'h1000, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);

    // reset in the middle of ADD (idx=2): abort, no done pulse
    @(negedge clk);
    start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_before_abort", busy, 1);
    #5 rst_n = 1'b0;
    #1;
    chk_all_zero();
    @(negedge clk);
    #5 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    repeat (20) begin
      if (q.size() != 0) @(negedge clk);
    end
    if (q.size() != 0) chk("pending_results", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
